// File: rtl/regfile_dump_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dump_pkg
// Shared definitions for the register-file dump reader: FSM state encodings
// (also used by the bench for state checks), default widths, and the
// start-range validation helper.
// -----------------------------------------------------------------------------
package regfile_dump_pkg;

    // State encodings as plain constants so that other code can compare
    // against them without depending on the enum type.
    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_READ = 2'd1;
    localparam logic [1:0] STATE_HOLD = 2'd2;
    localparam logic [1:0] STATE_DONE = 2'd3;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_NUM_REGS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_READ = STATE_READ,
        ST_HOLD = STATE_HOLD,
        ST_DONE = STATE_DONE
    } dump_state_e;

    // A range is rejected when it is reversed or runs past the last
    // implemented register. Operands are zero-extended to 32 bits so the
    // check stays correct even when NUM_REGS equals 2**ADDR_WIDTH.
    function automatic logic range_bad(input logic [31:0] first_a,
                                       input logic [31:0] last_a,
                                       input logic [31:0] num_regs);
        range_bad = (first_a > last_a) || (last_a >= num_regs);
    endfunction

endpackage

// File: rtl/dump_addr_counter.sv
// -----------------------------------------------------------------------------
// dump_addr_counter
// Read-address generator for the dump reader. Loads the first address and
// latches the last address of a range, increments on request, and flags when
// the current address is the last one of the range.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load_i       load first_i into the address, latch last_i
//   inc_i        advance the address by one
//   first_i      first address of the range
//   last_i       last address of the range (inclusive)
//   addr_o       current read address (registered)
//   is_last_o    addr_o equals the latched last address
// -----------------------------------------------------------------------------
module dump_addr_counter #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH-1:0] first_i,
    input  logic [ADDR_WIDTH-1:0] last_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  is_last_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH-1:0] last_q;
    logic [ADDR_WIDTH-1:0] last_d;

    // Next address / latched bound: load has priority over increment.
    // The range is validated before load, so the increment never wraps.
    always_comb begin
        addr_d = addr_q;
        last_d = last_q;
        if (load_i) begin
            addr_d = first_i;
            last_d = last_i;
        end else if (inc_i) begin
            addr_d = addr_q + ADDR_ONE;
        end else begin
            addr_d = addr_q;
        end
    end

    // Address and last-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= {ADDR_WIDTH{1'b0}};
            last_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            addr_q <= addr_d;
            last_q <= last_d;
        end
    end

    assign addr_o    = addr_q;
    assign is_last_o = (addr_q == last_q);

endmodule

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
// Debug readout engine: walks [first_addr..last_addr] over a spare register
// file read port and streams each word on a valid/ready interface tagged
// with its address and a last flag. Never writes the register file.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, abort          request a dump (IDLE only) / synchronous abort
//   first_addr, last_addr inclusive range, sampled with start
//   rd_addr, rd_data      register-file read port (data combinational)
//   out_valid, out_ready  output handshake
//   out_data, out_addr    captured word and its address
//   out_last              word is the last of the range
//   busy, done, err       status: active / end-of-dump pulse / rejected-start pulse
// -----------------------------------------------------------------------------
module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    dump_state_e           state_q;
    dump_state_e           state_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic                  out_last_q;
    logic                  out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [ADDR_WIDTH-1:0] out_addr_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;
    logic                  err_q;
    logic                  err_d;

    logic                  load_s;
    logic                  inc_s;
    logic                  is_last_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic                  bad_range_s;

    assign bad_range_s = range_bad(32'(first_addr), 32'(last_addr), 32'(NUM_REGS));

    dump_addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_counter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_s),
        .inc_i     (inc_s),
        .first_i   (first_addr),
        .last_i    (last_addr),
        .addr_o    (rd_addr_s),
        .is_last_o (is_last_s)
    );

    // Next-state and next-output logic. Abort overrides every other input.
    // done is raised on the HOLD->DONE transition so it is visible while
    // the FSM sits in DONE, one cycle after the last word is accepted.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load_s      = 1'b0;
        inc_s       = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (bad_range_s) begin
                            err_d = 1'b1;
                        end else begin
                            load_s  = 1'b1;
                            busy_d  = 1'b1;
                            state_d = ST_READ;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_READ: begin
                    // Snapshot the word now; later register writes cannot
                    // disturb what is presented downstream.
                    out_data_d  = rd_data;
                    out_addr_d  = rd_addr_s;
                    out_last_d  = is_last_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (out_last_q) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            inc_s   = 1'b1;
                            state_d = ST_READ;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= {DATA_WIDTH{1'b0}};
            out_addr_q  <= {ADDR_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rd_addr   = rd_addr_s;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
// Scoreboard bench: expected words are queued when a dump is started and
// compared as the DUT hands them over. ADDR_WIDTH is 6 so an out-of-range
// last address of 32 can be presented with NUM_REGS=32.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;
    import regfile_dump_pkg::*;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    logic [DW-1:0] regs [64];
    exp_t          sb [$];
    exp_t          e;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    int snap;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    regfile_dump_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input int f, input int l);
        exp_t x;
        first_addr = f[AW-1:0];
        last_addr  = l[AW-1:0];
        start      = 1'b1;
        if (!(f > l || l >= NR)) begin
            for (int a = f; a <= l; a++) begin
                x.addr = a[AW-1:0];
                x.data = 32'hA000_0000 + a;
                x.last = (a == l);
                sb.push_back(x);
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 400; i++) begin
            if (!busy && sb.size() == 0) break;
            tick();
        end
        check_val(tag, 64'(busy), 64'd0);
        check_val({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every accepted word.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow_addr", 64'(out_addr), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check_val("word_data", 64'(out_data), 64'(e.data));
                    check_val("word_addr", 64'(out_addr), 64'(e.addr));
                    check_val("word_last", 64'(out_last), 64'(e.last));
                    if (e.last) last_hs_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check_val("done_with_valid", 64'(out_valid), 64'd0);
            end
            if (err) err_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 32'hA000_0000 + i;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        first_addr = '0; last_addr = '0;
        #1;
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        check_val("rst_last", 64'(out_last), 64'd0);
        check_val("rst_rd_addr", 64'(rd_addr), 64'd0);
        check_val("rst_out_data", 64'(out_data), 64'd0);
        check_val("rst_out_addr", 64'(out_addr), 64'd0);
        check_val("rst_state", 64'(dut.state_q), 64'(STATE_IDLE));
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: plain dump 3..6, latency and done timing
        start_dump(3, 6);
        check_val("lat_edge1_valid", 64'(out_valid), 64'd0);
        check_val("lat_busy", 64'(busy), 64'd1);
        tick();
        check_val("lat_edge2_valid", 64'(out_valid), 64'd1);
        check_val("lat_first_addr", 64'(out_addr), 64'd3);
        wait_idle("t1_idle");
        check_val("t1_done_cnt", 64'(done_cnt), 64'd1);
        check_val("t1_done_gap", 64'(done_cyc - last_hs_cyc), 64'd1);

        // 2: stall 5 cycles on addr 4 while the register is overwritten
        start_dump(3, 6);
        for (int i = 0; i < 50; i++) begin
            if (out_valid && out_addr == 6'd4) break;
            tick();
        end
        check_val("t2_reach_addr4", 64'(out_addr), 64'd4);
        out_ready = 1'b0;
        regs[4] = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t2_hold_data", 64'(out_data), 64'hA000_0004);
            check_val("t2_hold_valid", 64'(out_valid), 64'd1);
            check_val("t2_hold_rd_addr", 64'(rd_addr), 64'd4);
        end
        regs[4] = 32'hA000_0004;
        out_ready = 1'b1;
        wait_idle("t2_idle");
        check_val("t2_done_cnt", 64'(done_cnt), 64'd2);

        // 3: rejected ranges
        start_dump(7, 2);
        check_val("t3_err_pulse", 64'(err), 64'd1);
        check_val("t3_busy", 64'(busy), 64'd0);
        tick();
        check_val("t3_err_clear", 64'(err), 64'd0);
        check_val("t3_valid", 64'(out_valid), 64'd0);
        start_dump(0, 32);
        check_val("t3_oor_err", 64'(err), 64'd1);
        check_val("t3_oor_busy", 64'(busy), 64'd0);
        tick();
        check_val("t3_err_cnt", 64'(err_cnt), 64'd2);

        // 4: single-word range
        start_dump(0, 0);
        wait_idle("t4_idle");
        check_val("t4_done_cnt", 64'(done_cnt), 64'd3);

        // 5: abort in HOLD at addr 10, then abort+start together, then restart
        start_dump(0, 31);
        for (int i = 0; i < 100; i++) begin
            if (out_valid && out_addr == 6'd10) break;
            tick();
        end
        check_val("t5_reach_addr10", 64'(out_addr), 64'd10);
        out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("t5_abort_valid", 64'(out_valid), 64'd0);
        check_val("t5_abort_busy", 64'(busy), 64'd0);
        check_val("t5_abort_last", 64'(out_last), 64'd0);
        check_val("t5_abort_state", 64'(dut.state_q), 64'(STATE_IDLE));
        check_val("t5_sb_left", 64'(sb.size()), 64'd22);
        sb.delete();
        out_ready = 1'b1;
        first_addr = 6'd5; last_addr = 6'd3; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_val("t5_abort_start_busy", 64'(busy), 64'd0);
        check_val("t5_abort_start_err", 64'(err), 64'd0);
        tick(); tick();
        check_val("t5_no_done", 64'(done_cnt), 64'd3);
        check_val("t5_no_err", 64'(err_cnt), 64'd2);
        start_dump(0, 1);
        wait_idle("t5_idle");
        check_val("t5_done_cnt", 64'(done_cnt), 64'd4);

        // 6: start during busy ignored, then asynchronous reset mid-dump
        start_dump(0, 31);
        repeat (4) tick();
        first_addr = 6'd20; last_addr = 6'd25; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("t6_busy_kept", 64'(busy), 64'd1);
        repeat (6) tick();
        snap = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_rst_valid", 64'(out_valid), 64'd0);
        check_val("t6_rst_busy", 64'(busy), 64'd0);
        check_val("t6_rst_rd_addr", 64'(rd_addr), 64'd0);
        check_val("t6_rst_out_data", 64'(out_data), 64'd0);
        check_val("t6_rst_out_addr", 64'(out_addr), 64'd0);
        check_val("t6_rst_state", 64'(dut.state_q), 64'(STATE_IDLE));
        sb.delete();
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        check_val("t6_no_done", 64'(done_cnt), 64'(snap));
        check_val("t6_done_low", 64'(done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
